// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: duty width, default period and
// the ramp controller state encoding.
package pwm_pkg;
  localparam int unsigned DUTY_W        = 32;
  localparam int unsigned PWM_MAX_COUNT = 255;

  typedef enum logic {IDLE, RAMP} ramp_state_t;
endpackage

// File: rtl/ramp_tick_gen.sv
// Interval counter: pulses tick on the cycle the count sits at INTERVAL-1,
// wraps to 0 on that edge, holds while run is low.
module ramp_tick_gen #(
  parameter int unsigned INTERVAL = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int unsigned   CNT_W = $clog2(INTERVAL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (run)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/duty_ramp_controller.sv
// Accepts duty setpoints over valid/ready and slews duty_cycle toward them by
// at most STEP_SIZE counts every STEP_INTERVAL enabled clocks.
module duty_ramp_controller
  import pwm_pkg::*;
#(
  parameter int unsigned MAX_COUNT     = PWM_MAX_COUNT,
  parameter int unsigned STEP_SIZE     = 4,
  parameter int unsigned STEP_INTERVAL = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic              enable,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done,
  output logic              clamped
);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(MAX_COUNT);
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP_SIZE);

  ramp_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, tgt_q, tgt_d;
  logic              done_q, done_d, clamped_q, clamped_d;
  logic              clear, tick;
  logic [DUTY_W-1:0] tgt_in, diff, stp;

  ramp_tick_gen #(.INTERVAL(STEP_INTERVAL)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .run   ((state_q == RAMP) && enable),
    .tick  (tick)
  );

  assign tgt_in = (target_duty > MAX_V) ? MAX_V : target_duty;
  // Unsigned magnitude of the remaining distance; the step never exceeds it.
  assign diff   = (tgt_q >= duty_q) ? (tgt_q - duty_q) : (duty_q - tgt_q);
  assign stp    = (diff < STEP_V) ? diff : STEP_V;

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_valid) begin
          clear     = 1'b1;
          tgt_d     = tgt_in;
          clamped_d = (target_duty > MAX_V);
          if (tgt_in != duty_q) state_d = RAMP;
          else                  done_d  = 1'b1;
        end
      end
      RAMP: begin
        if (tick) begin
          duty_d = (tgt_q > duty_q) ? (duty_q + stp) : (duty_q - stp);
          if (duty_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      tgt_q     <= '0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q == RAMP);
  assign duty_cycle   = duty_q;
  assign done         = done_q;
  assign clamped      = clamped_q;
endmodule

// File: tb/tb_duty_ramp_controller.sv
// Scoreboard bench: stimulus queues expected output events (duty change,
// done or clamped pulse) with their cycle; a monitor pops and compares.
module tb_duty_ramp_controller;
  import pwm_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [DUTY_W-1:0] target_duty;
  logic              target_valid, target_ready, enable;
  logic [DUTY_W-1:0] duty_cycle;
  logic              busy, done, clamped;

  duty_ramp_controller #(.MAX_COUNT(255), .STEP_SIZE(4), .STEP_INTERVAL(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .target_duty  (target_duty),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .enable       (enable),
    .duty_cycle   (duty_cycle),
    .busy         (busy),
    .done         (done),
    .clamped      (clamped)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] duty;
    logic        done;
    logic        clamped;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] prev_duty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int d, input bit dn, input bit cl);
    exp_t e;
    e.cyc = c; e.duty = d; e.done = dn; e.clamped = cl;
    sbq.push_back(e);
  endtask

  // Monitor: every duty change or done/clamped pulse must match the head entry.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("duty_in_range", 32'(duty_cycle <= 255), 1);
      if (duty_cycle !== prev_duty || done || clamped) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event @cyc %0d: duty=%0d done=%0d clamped=%0d",
                   cyc, duty_cycle, done, clamped);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_duty", duty_cycle, e.duty);
          chk("event_done", 32'(done), 32'(e.done));
          chk("event_clamped", 32'(clamped), 32'(e.clamped));
        end
      end
      prev_duty = duty_cycle;
    end
  end

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [31:0] v);
    target_duty  = v;
    target_valid = 1'b1;
    @(negedge clock);
    target_valid = 1'b0;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while (sbq.size() != 0 && k < maxc) begin
      @(negedge clock);
      k++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int a;
    reset = 1'b1; target_duty = '0; target_valid = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_ready", 32'(target_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_clamped", 32'(clamped), 0);
    reset = 1'b0;
    prev_duty = duty_cycle;
    mon_en = 1'b1;

    // Up-ramp 0 -> 10
    a = cyc + 1;
    push(a + 4, 4, 0, 0); push(a + 8, 8, 0, 0); push(a + 12, 10, 1, 0);
    issue(10);
    step_to(a + 1);
    chk("up_ready_busy", 32'(target_ready), 0);
    chk("up_busy", 32'(busy), 1);
    step_to(a + 12);
    chk("up_ready_after", 32'(target_ready), 1);
    wait_drain(8);

    // Down-ramp 10 -> 0
    a = cyc + 1;
    push(a + 4, 6, 0, 0); push(a + 8, 2, 0, 0); push(a + 12, 0, 1, 0);
    issue(0);
    wait_drain(20);

    // Clamp: 300 -> 255
    a = cyc + 1;
    push(a, 0, 0, 1);
    for (int k = 1; k <= 63; k++) push(a + 4 * k, 4 * k, 0, 0);
    push(a + 256, 255, 1, 0);
    issue(300);
    wait_drain(300);

    // Busy rejection and pause: 255 -> 245, 7-cycle enable drop
    a = cyc + 1;
    push(a + 4, 251, 0, 0); push(a + 15, 247, 0, 0); push(a + 19, 245, 1, 0);
    issue(245);
    step_to(a + 1);
    target_duty = 50; target_valid = 1'b1;
    step_to(a + 2);
    chk("busy_ready_low", 32'(target_ready), 0);
    step_to(a + 4);
    target_valid = 1'b0;
    step_to(a + 5);
    enable = 1'b0;
    step_to(a + 10);
    chk("pause_duty_hold", duty_cycle, 251);
    chk("pause_busy", 32'(busy), 1);
    step_to(a + 12);
    enable = 1'b1;
    wait_drain(30);

    // Equal target: immediate done, never busy
    a = cyc + 1;
    push(a, 245, 1, 0);
    issue(245);
    chk("eq_busy_a", 32'(busy), 0);
    @(negedge clock);
    chk("eq_busy_a1", 32'(busy), 0);
    wait_drain(5);

    // Mid-ramp reset: 245 -> 10, reset sampled at A+5
    a = cyc + 1;
    push(a + 4, 241, 0, 0); push(a + 5, 0, 0, 0);
    issue(10);
    step_to(a + 4);
    reset = 1'b1;
    step_to(a + 5);
    reset = 1'b0;
    chk("mrst_duty", duty_cycle, 0);
    chk("mrst_ready", 32'(target_ready), 1);
    chk("mrst_busy", 32'(busy), 0);
    repeat (10) @(negedge clock);
    wait_drain(5);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
